// File: rtl/clint.sv
// Core-local interruptor: mtime/mtimecmp/msip on the native valid/ready port.
// Optional mtime prescaler enabled by defining CLINT_PRESCALER_EN.
module clint #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mtip,
    output logic        msip,
    output logic [63:0] mtime
);

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    state_t      state;
    logic [63:0] mtimecmp;
    logic [15:0] off;
    logic        accept;
    logic        wr;
    logic        wr_tlo;
    logic        wr_thi;
    logic        tick;
    logic [31:0] rd_val;

    function automatic logic [31:0] merge(
        input logic [31:0] old,
        input logic [31:0] data,
        input logic [3:0]  strb
    );
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = strb[i] ? data[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

    assign off    = {mem_addr[15:2], 2'b00};
    assign accept = (state == IDLE) && mem_valid;
    assign wr     = accept && (mem_wstrb != 4'b0000);
    assign wr_tlo = wr && (off == 16'hBFF8);
    assign wr_thi = wr && (off == 16'hBFFC);

`ifdef CLINT_PRESCALER_EN
    logic [15:0] pcnt;
    logic        unused_addr;

    assign unused_addr = ^{mem_addr[31:16], mem_addr[1:0]};
    assign tick        = (pcnt == 16'(PRESCALE - 1));

    // Free-running; bus writes to mtime leave the phase untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pcnt <= '0;
        else if (tick)
            pcnt <= '0;
        else
            pcnt <= pcnt + 16'd1;
    end
`else
    logic unused_addr;

    assign unused_addr = ^{mem_addr[31:16], mem_addr[1:0], 16'(PRESCALE)};
    assign tick        = 1'b1;
`endif

    always_comb begin
        rd_val = '0;
        case (off)
            16'h0000: rd_val = {31'b0, msip};
            16'h4000: rd_val = mtimecmp[31:0];
            16'h4004: rd_val = mtimecmp[63:32];
            16'hBFF8: rd_val = mtime[31:0];
            16'hBFFC: rd_val = mtime[63:32];
            default:  rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            msip      <= 1'b0;
            mtip      <= 1'b0;
            mtimecmp  <= '1;
            mtime     <= '0;
        end else begin
            mtip <= (mtime >= mtimecmp);

            // A write to either half wins over the tick, with no carry.
            if (wr_tlo)
                mtime[31:0] <= merge(mtime[31:0], mem_wdata, mem_wstrb);
            else if (wr_thi)
                mtime[63:32] <= merge(mtime[63:32], mem_wdata, mem_wstrb);
            else if (tick)
                mtime <= mtime + 64'd1;

            if (wr && off == 16'h0000 && mem_wstrb[0])
                msip <= mem_wdata[0];
            if (wr && off == 16'h4000)
                mtimecmp[31:0] <= merge(mtimecmp[31:0], mem_wdata, mem_wstrb);
            if (wr && off == 16'h4004)
                mtimecmp[63:32] <= merge(mtimecmp[63:32], mem_wdata, mem_wstrb);

            case (state)
                IDLE: begin
                    if (mem_valid) begin
                        state     <= RESP;
                        mem_ready <= 1'b1;
                        mem_rdata <= rd_val;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    mem_ready <= 1'b0;
                    mem_rdata <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clint.sv
// Directed bench for clint with a read-data scoreboard.
// Prescaler section follows CLINT_PRESCALER_EN with PRESCALE = 4.
module tb_clint;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mtip;
    logic        msip;
    logic [63:0] mtime;

    clint #(.PRESCALE(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .mtip      (mtip),
        .msip      (msip),
        .mtime     (mtime)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mode 0: equal, 1: at least, 2: not compared
    typedef struct {
        string       tag;
        logic [31:0] exp;
        int          mode;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_cmp();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_empty observed ready with no pending entry");
            return;
        end
        e = sb.pop_front();
        if (e.mode == 0) begin
            check(e.tag, {32'b0, mem_rdata}, {32'b0, e.exp});
        end else if (e.mode == 1) begin
            checks++;
            assert (mem_rdata >= e.exp) else begin
                errors++;
                $error("FAIL %s observed %h expected >= %h",
                       e.tag, mem_rdata, e.exp);
            end
        end
    endtask

    // Called at a negedge; returns at the negedge where mem_ready is seen.
    task automatic bus(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input string tag,
                       input logic [31:0] e, input int mode);
        bit got;
        sb.push_back('{tag, e, mode});
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
        got = 0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk);
            if (mem_ready) got = 1;
        end
        mem_valid = 1'b0;
        mem_wstrb = 4'b0000;
        if (!got) begin
            checks++;
            errors++;
            $error("FAIL %s_timeout observed no mem_ready expected pulse", tag);
            void'(sb.pop_front());
        end else begin
            pop_cmp();
        end
    endtask

    initial begin
        logic [63:0] m0;
        int          rcnt;
        bit          dbl;
        bit          prev;
        bit          hit;

        rst       = 1'b1;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", {63'b0, mem_ready}, 64'd0);
        check("rst_rdata", {32'b0, mem_rdata}, 64'd0);
        check("rst_mtime", mtime, 64'd0);
        check("rst_mtip", {63'b0, mtip}, 64'd0);
        check("rst_msip", {63'b0, msip}, 64'd0);
        rst = 1'b0;

        repeat (10) @(negedge clk);
        bus(32'hBFF8, 0, 4'h0, "rd_mtime_lo", 32'd10, 1);
        bus(32'h4004, 0, 4'h0, "rd_cmp_hi", 32'hFFFF_FFFF, 0);
        check("idle_mtip", {63'b0, mtip}, 64'd0);

        bus(32'h0000, 32'hFFFF_FFFF, 4'hF, "wr_msip", 32'd0, 0);
        check("msip_set", {63'b0, msip}, 64'd1);
        bus(32'h0000, 0, 4'h0, "rd_msip", 32'd1, 0);
        bus(32'h0000, 0, 4'hF, "clr_msip", 32'd1, 0);
        check("msip_clr", {63'b0, msip}, 64'd0);

        bus(32'h4004, 0, 4'hF, "wr_cmp_hi", 32'hFFFF_FFFF, 0);
        bus(32'h4000, 32'd50, 4'hF, "wr_cmp_lo", 32'hFFFF_FFFF, 0);
        check("mtip_pre", {63'b0, mtip}, 64'd0);
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            if (mtime == 64'd50) hit = 1;
            else @(negedge clk);
        end
        check("mtime_hit50", {63'b0, hit}, 64'd1);
        check("mtip_at50", {63'b0, mtip}, 64'd0);
        @(negedge clk);
        check("mtip_rise", {63'b0, mtip}, 64'd1);
        bus(32'h4004, 32'd1, 4'hF, "wr_cmp_hi1", 32'd0, 0);
        check("mtip_hold", {63'b0, mtip}, 64'd1);
        @(negedge clk);
        check("mtip_fall", {63'b0, mtip}, 64'd0);

        bus(32'hBFFC, 32'hFFFF_FFFF, 4'hF, "wr_mtime_hi", 32'd0, 0);
        bus(32'hBFF8, 32'hFFFF_FFFF, 4'hF, "wr_mtime_lo", 32'd0, 2);
        check("mtime_max", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        check("mtime_wrap", mtime, 64'd0);
        bus(32'hBFF8, 32'h1234_5678, 4'hF, "wr_lo_full", 32'd0, 0);
        check("mtime_full", mtime, 64'h0000_0000_1234_5678);
        bus(32'hBFF8, 32'h0000_AB00, 4'b0010, "wr_lo_b1", 32'h1234_5679, 0);
        check("mtime_byte1", mtime, 64'h0000_0000_1234_AB79);
        @(negedge clk);
        check("mtime_resume", mtime, 64'h0000_0000_1234_AB7A);

        mem_valid = 1'b1;
        mem_addr  = 32'h1234;
        mem_wstrb = 4'h0;
        for (int i = 0; i < 4; i++) sb.push_back('{"rd_hole", 32'd0, 0});
        rcnt = 0;
        dbl  = 0;
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mem_ready) begin
                rcnt++;
                if (prev) dbl = 1;
                pop_cmp();
            end
            prev = mem_ready;
        end
        mem_valid = 1'b0;
        check("stream_pulses", 64'(rcnt), 64'd4);
        check("stream_gap", {63'b0, dbl}, 64'd0);
        bus(32'h0000, 0, 4'h0, "rd_msip2", 32'd0, 0);
        bus(32'h4004, 0, 4'h0, "rd_cmp_hi2", 32'd1, 0);

        @(negedge clk);
        m0 = mtime;
`ifdef CLINT_PRESCALER_EN
        repeat (12) @(negedge clk);
        check("presc_rate", mtime - m0, 64'd3);
`else
        repeat (5) @(negedge clk);
        check("tick_rate", mtime - m0, 64'd5);
`endif

        mem_valid = 1'b1;
        mem_addr  = 32'h0000;
        mem_wdata = 32'd1;
        mem_wstrb = 4'h1;
        @(posedge clk);
        #1;
        check("mid_ready", {63'b0, mem_ready}, 64'd1);
        rst = 1'b1;
        #1;
        check("abort_ready", {63'b0, mem_ready}, 64'd0);
        check("abort_rdata", {32'b0, mem_rdata}, 64'd0);
        check("abort_msip", {63'b0, msip}, 64'd0);
        check("abort_mtime", mtime, 64'd0);
        check("abort_mtip", {63'b0, mtip}, 64'd0);
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        @(negedge clk);
        rst = 1'b0;
        bus(32'h4004, 0, 4'h0, "post_cmp_hi", 32'hFFFF_FFFF, 0);
        bus(32'hBFFC, 0, 4'h0, "post_mtime_hi", 32'd0, 0);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clint.md
# clint

Core-local interruptor for the single-hart core: the producer side of the machine timer and software interrupt lines that the CSR unit consumes. It holds the 64-bit `mtime` counter, the 64-bit `mtimecmp` compare register and the `msip` bit. These are exposed on the core's native valid/ready memory port. It drives `mtip`, `msip` and `mtime` straight into the CSR block. The platform interconnect decodes the CLINT base address and asserts `mem_valid` here only for CLINT accesses.

## Interface
Parameters:
- `PRESCALE`, default 1: clock cycles per `mtime` increment. Used only when `CLINT_PRESCALER_EN` is defined; legal range 1..65535.

Ports:
- Clocking and reset (already decided): one clock, `clk`; reset `rst` is asynchronous and active-high.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous reset, active-high.
- `mem_valid`  in  1  request present; held by the master until `mem_ready`.
- `mem_addr`  in  32  byte address; only `[15:0]` is decoded.
- `mem_wdata`  in  32  write data.
- `mem_wstrb`  in  4  byte write enables; 0 means read.
- `mem_rdata`  out  32  read data; valid while `mem_ready` = 1, otherwise 0.
- `mem_ready`  out  1  one-cycle response pulse.
- `mtip`  out  1  machine timer interrupt pending.
- `msip`  out  1  machine software interrupt pending.
- `mtime`  out  64  current time value.

## Operation
Register map (offset `addr[15:0]`, 32-bit words; `addr[1:0]` ignored):
- 0x0000 `msip`: bit 0 is read/write; bits 31:1 read 0 and ignore writes.
- 0x4000 / 0x4004: `mtimecmp[31:0]` / `mtimecmp[63:32]`.
- 0xBFF8 / 0xBFFC: `mtime[31:0]` / `mtime[63:32]`.
- Any other offset reads 0, ignores writes, and still responds with `mem_ready`.

Writes:
- Writes honour `mem_wstrb` per byte.
- Unselected bytes keep their value.

Bus FSM:
- IDLE: when `mem_valid` = 1, the write is performed at this edge and read data is captured from the pre-write register values. Next state is RESP.
- RESP: `mem_ready` = 1 and `mem_rdata` is driven. `mem_valid` is ignored in this cycle. Next state is IDLE.

Counter:
- `mtime` increments by 1 on each tick and wraps from 2^64-1 to 0.
- A bus write to either `mtime` half replaces that half with the merged write data. The other half keeps its current value. No increment occurs in that cycle; the write wins and there is no carry between halves.

Interrupt outputs:
- `mtip` is registered: `mtip` <= (`mtime` >= `mtimecmp`), unsigned 64-bit compare, using the register values before the edge.
- `msip` is the `msip` register bit.
- `mtime` is the counter register output, unregistered.

Reset values:
- `mtime` = 0; `mtimecmp` = 0xFFFF_FFFF_FFFF_FFFF; `msip` = 0; `mtip` = 0.
- `mem_ready` = 0; `mem_rdata` = 0.
- FSM = IDLE; prescaler count = 0.
- Reset asserted mid-transaction aborts it: no `mem_ready` pulse is issued, and any write not yet clocked is lost.

## Timing
- Fixed 1-cycle latency: `mem_valid` sampled high in IDLE at edge N gives `mem_ready` high in cycle N+1. Minimum spacing is one request per 2 cycles.
- A register write is visible on `msip` / `mtime` in the cycle after the accept edge.
- `mtip` reflects a `mtimecmp` or `mtime` write one cycle later again, i.e. 2 cycles after the accept edge.
- `mtip` rises exactly 1 cycle after `mtime` first equals `mtimecmp`.
- `mtip` clears 2 cycles after the accept edge of a `mtimecmp` write that raises the compare above `mtime`.

## Configuration
- `CLINT_PRESCALER_EN` defined:
  - A 16-bit prescaler counts 0..`PRESCALE`-1.
  - `mtime` ticks on the edge where the prescaler count equals `PRESCALE`-1; the prescaler then returns to 0.
  - Bus writes do not reset the prescaler.
- `CLINT_PRESCALER_EN` undefined: there is no prescaler logic, `PRESCALE` is ignored, and `mtime` ticks every cycle.

## Test plan
- Reset then idle 10 cycles: read 0xBFF8 returns a value ≥ 10; read 0x4004 returns 0xFFFF_FFFF; `mtip` = 0, `msip` = 0.
- Write 0x0000 = 0xFFFF_FFFF, then read it: `msip` goes high the cycle after accept; readback is 0x0000_0001; writing 0 clears `msip`.
- Write 0x4004 = 0, then write 0x4000 = 50: `mtip` rises 1 cycle after `mtime` = 50. Then write 0x4004 = 1: `mtip` falls 2 cycles after that accept edge.
- Write 0xBFF8 = 0xFFFF_FFFF and 0xBFFC = 0xFFFF_FFFF: `mtime` wraps to 0 on the next tick. Write with `mem_wstrb` = 4'b0010, data 0xAB00, to 0xBFF8: only byte 1 changes.
- Hold `mem_valid` high continuously with reads to 0x1234: `mem_ready` pulses every other cycle, `mem_rdata` = 0, and no register changes.
- With `CLINT_PRESCALER_EN` and `PRESCALE` = 4: `mtime` advances by 1 every 4 cycles; reset asserted mid-request suppresses `mem_ready` and restores all reset values.
